// File: rtl/rv_pkg.sv
// ============================================================================
// rv_pkg -- constants and FSM encoding shared by the fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// if_id_reg -- IF/ID pipeline register with flush (bubble) and hold controls
// Rev 1.0
// ============================================================================
`default_nettype none

module if_id_reg
  import rv_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  // Priority: flush > hold > load > bubble. Bubbles keep the last pc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_WORD;
      pc_q    <= 32'h0000_0000;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_WORD;
    end else if (hold_i) begin
      valid_q <= valid_q;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else begin
      valid_q <= 1'b0;
      instr_q <= NOP_WORD;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage -- single-outstanding instruction fetch with skid and redirect
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = rv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc
);

  import rv_pkg::*;

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  target_q;
  logic [31:0]  skid_instr_q;
  logic         skid_valid_q;
  logic         req_q;

  logic         w_accept;
  logic [31:0]  w_redir_pc;
  logic         w_flush;
  logic         w_load;
  logic [31:0]  w_load_instr;

  assign w_accept   = req_q & imem_valid;
  assign w_redir_pc = align_pc(redirect_pc);

  // pc_q is the address on the bus; in DISCARD it stays on the abandoned
  // request while target_q carries where fetching resumes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      target_q     <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      req_q        <= 1'b1;
    end else begin
      case (state_q)
        FETCH: begin
          if (redirect_valid) begin
            skid_valid_q <= 1'b0;
            if (w_accept) begin
              pc_q <= w_redir_pc;
            end else begin
              target_q <= w_redir_pc;
              state_q  <= DISCARD;
            end
          end else if (w_accept && !stall) begin
            pc_q <= pc_q + PC_STEP;
          end else if (w_accept && stall) begin
            skid_instr_q <= imem_rdata;
            skid_valid_q <= 1'b1;
            state_q      <= HOLD;
            req_q        <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_q         <= w_redir_pc;
            skid_valid_q <= 1'b0;
            state_q      <= FETCH;
            req_q        <= 1'b1;
          end else if (!stall) begin
            pc_q         <= pc_q + PC_STEP;
            skid_valid_q <= 1'b0;
            state_q      <= FETCH;
            req_q        <= 1'b1;
          end
        end
        DISCARD: begin
          if (w_accept) begin
            pc_q    <= redirect_valid ? w_redir_pc : target_q;
            state_q <= FETCH;
          end else if (redirect_valid) begin
            target_q <= w_redir_pc;
          end
        end
        default: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;

  assign w_flush      = redirect_valid | (state_q == DISCARD);
  assign w_load       = ((state_q == HOLD) && skid_valid_q) || w_accept;
  assign w_load_instr = (state_q == HOLD) ? skid_instr_q : imem_rdata;

  if_id_reg #(
    .NOP_WORD (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .flush_i (w_flush),
    .hold_i  (stall),
    .load_i  (w_load),
    .instr_i (w_load_instr),
    .pc_i    (pc_q),
    .valid_o (if_id_valid),
    .instr_o (if_id_instr),
    .pc_o    (if_id_pc)
  );

endmodule

`default_nettype wire
